// File: rtl/noc_traffic_gen.sv
// Synthetic NoC flit source: LFSR-paced injection, uniform/transpose/hotspot
// destination selection, valid/busy handshake with stall and flit counters.
module noc_traffic_gen #(
    parameter int unsigned ID           = 0,
    parameter int unsigned MESH_W       = 3,
    parameter int unsigned ADDR_BITS    = 4,
    parameter int unsigned PAYLOAD_SIZE = 16,
    parameter int unsigned PIR          = 255,
    parameter int unsigned MODE         = 0,
    parameter int unsigned HOTSPOT      = 4,
    parameter int unsigned HOT_PCT      = 64,
    parameter int unsigned MAX_PKTS     = 0,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              send,
    input  logic                              busy,
    output logic [PAYLOAD_SIZE+ADDR_BITS-1:0] data,
    output logic                              valid,
    output logic [19:0]                       flit_count,
    output logic [19:0]                       stall_count,
    output logic                              done
);

    localparam int unsigned NUM_NODES   = MESH_W * MESH_W;
    localparam int unsigned DATA_W      = PAYLOAD_SIZE + ADDR_BITS;
    localparam int unsigned MOD_W       = ADDR_BITS + 8;
    localparam int unsigned CNT_W       = 20;
    localparam logic [15:0] SEED_MIX    = SEED ^ 16'(ID);
    localparam logic [15:0] LFSR16_INIT = (SEED_MIX == 16'd0) ? 16'd1 : SEED_MIX;
    localparam logic [7:0]  LFSR8_INIT  = (LFSR16_INIT[7:0] == 8'd0) ? 8'd1 : LFSR16_INIT[7:0];
    localparam int unsigned TR_X        = ID % MESH_W;
    localparam int unsigned TR_Y        = ID / MESH_W;
    localparam int unsigned TR_DEST     = TR_X * MESH_W + TR_Y;
    localparam bit          TR_DIAG     = (MODE == 1) && (TR_X == TR_Y);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              lfsr8_q, lfsr8_d;
    logic [15:0]             lfsr16_q, lfsr16_d;
    logic [PAYLOAD_SIZE-1:0] seq_q, seq_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    valid_q, valid_d;
    logic [CNT_W-1:0]        flit_q, flit_d;
    logic [CNT_W-1:0]        stall_q, stall_d;
    logic                    done_q, done_d;

    logic [MOD_W-1:0]     mod_res;
    logic [ADDR_BITS-1:0] mod_dest;
    logic [ADDR_BITS-1:0] uni_dest;
    logic [ADDR_BITS-1:0] dest_c;
    logic                 inject_c;
    logic [CNT_W-1:0]     flit_inc;

    // Destination select; uniform rule bumps past our own node index
    always_comb begin
        mod_res  = lfsr16_q[MOD_W-1:0] % MOD_W'(NUM_NODES);
        mod_dest = ADDR_BITS'(mod_res);
        uni_dest = mod_dest;
        if (mod_dest == ADDR_BITS'(ID)) begin
            uni_dest = (ID + 1 == NUM_NODES) ? '0 : ADDR_BITS'(ID + 1);
        end
        dest_c = uni_dest;
        if (MODE == 1) begin
            dest_c = ADDR_BITS'(TR_DEST);
        end else if (MODE == 2) begin
            if ((32'(lfsr16_q[15:8]) < HOT_PCT) && (ID != HOTSPOT)) begin
                dest_c = ADDR_BITS'(HOTSPOT);
            end
        end
    end

    assign inject_c = send && !done_q && (32'(lfsr8_q) <= PIR) && !TR_DIAG;
    assign flit_inc = (flit_q == CNT_MAX) ? flit_q : flit_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        data_d   = data_q;
        valid_d  = valid_q;
        flit_d   = flit_q;
        stall_d  = stall_q;
        done_d   = done_q;
        lfsr8_d  = {lfsr8_q[6:0], lfsr8_q[7] ^ lfsr8_q[5] ^ lfsr8_q[4] ^ lfsr8_q[3]};
        lfsr16_d = {lfsr16_q[14:0], lfsr16_q[15] ^ lfsr16_q[13] ^ lfsr16_q[12] ^ lfsr16_q[10]};
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (inject_c) begin
                    data_d  = {seq_q, dest_c};
                    seq_d   = seq_q + PAYLOAD_SIZE'(1);
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (busy) begin
                    stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_W'(1);
                end else begin
                    flit_d = flit_inc;
                    if ((MAX_PKTS != 0) && (32'(flit_inc) == MAX_PKTS)) begin
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                        state_d = S_DONE;
                    end else if (inject_c) begin
                        data_d = {seq_q, dest_c};
                        seq_d  = seq_q + PAYLOAD_SIZE'(1);
                    end else begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lfsr8_q  <= LFSR8_INIT;
            lfsr16_q <= LFSR16_INIT;
            seq_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            flit_q   <= '0;
            stall_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr8_q  <= lfsr8_d;
            lfsr16_q <= lfsr16_d;
            seq_q    <= seq_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            flit_q   <= flit_d;
            stall_q  <= stall_d;
            done_q   <= done_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign flit_count  = flit_q;
    assign stall_count = stall_q;
    assign done        = done_q;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench for noc_traffic_gen: several parameterisations share one
// stimulus bus; each scenario task checks its instance against hand values.
module tb_noc_traffic_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic send = 1'b0;
    logic busy = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    logic [19:0] d0, dtr5, dtr4, dmax, dh0, dh4, dp0;
    logic        v0, vtr5, vtr4, vmax, vh0, vh4, vp0;
    logic [19:0] fc0, fctr5, fctr4, fcmax, fch0, fch4, fcp0;
    logic [19:0] sc0, sctr5, sctr4, scmax, sch0, sch4, scp0;
    logic        dn0, dntr5, dntr4, dnmax, dnh0, dnh4, dnp0;

    noc_traffic_gen u0 (.clk(clk), .reset(reset), .send(send), .busy(busy), .data(d0),
        .valid(v0), .flit_count(fc0), .stall_count(sc0), .done(dn0));
    noc_traffic_gen #(.ID(5), .MODE(1)) u_tr5 (.clk(clk), .reset(reset), .send(send),
        .busy(busy), .data(dtr5), .valid(vtr5), .flit_count(fctr5), .stall_count(sctr5), .done(dntr5));
    noc_traffic_gen #(.ID(4), .MODE(1)) u_tr4 (.clk(clk), .reset(reset), .send(send),
        .busy(busy), .data(dtr4), .valid(vtr4), .flit_count(fctr4), .stall_count(sctr4), .done(dntr4));
    noc_traffic_gen #(.MAX_PKTS(3)) u_max (.clk(clk), .reset(reset), .send(send),
        .busy(busy), .data(dmax), .valid(vmax), .flit_count(fcmax), .stall_count(scmax), .done(dnmax));
    noc_traffic_gen #(.ID(0), .MODE(2), .HOTSPOT(4), .HOT_PCT(255)) u_h0 (.clk(clk), .reset(reset),
        .send(send), .busy(busy), .data(dh0), .valid(vh0), .flit_count(fch0), .stall_count(sch0), .done(dnh0));
    noc_traffic_gen #(.ID(4), .MODE(2), .HOTSPOT(4), .HOT_PCT(255)) u_h4 (.clk(clk), .reset(reset),
        .send(send), .busy(busy), .data(dh4), .valid(vh4), .flit_count(fch4), .stall_count(sch4), .done(dnh4));
    noc_traffic_gen #(.PIR(0)) u_p0 (.clk(clk), .reset(reset), .send(send), .busy(busy), .data(dp0),
        .valid(vp0), .flit_count(fcp0), .stall_count(scp0), .done(dnp0));

    function automatic logic [15:0] step16(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Uniform destination for a 3x3 mesh with 4-bit addresses
    function automatic logic [3:0] uni(input logic [15:0] l, input int unsigned id);
        int unsigned d;
        d = 32'(l[11:0]) % 32'd9;
        if (d == id) d = (d + 1) % 9;
        return 4'(d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; send = 1'b0; busy = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; send = 1'b1; busy = 1'b0;
        tick(); tick();
        total++; if (v0 !== 1'b0) $display("FAIL reset_valid got %b want 0", v0); else passed++;
        total++; if (d0 !== 20'h0) $display("FAIL reset_data got %h want 0", d0); else passed++;
        total++; if (fc0 !== 20'h0) $display("FAIL reset_flit got %0d want 0", fc0); else passed++;
        total++; if (sc0 !== 20'h0) $display("FAIL reset_stall got %0d want 0", sc0); else passed++;
        total++; if (dnmax !== 1'b0) $display("FAIL reset_done got %b want 0", dnmax); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] l;
        do_reset();
        l = 16'hACE1;
        send = 1'b1;
        total++; if (v0 !== 1'b0) $display("FAIL b2b_first_cycle_valid got %b want 0", v0); else passed++;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++; if (v0 !== 1'b1) $display("FAIL b2b_valid k=%0d got %b want 1", k, v0); else passed++;
            total++;
            if (d0[19:4] !== 16'(k - 1)) $display("FAIL b2b_payload k=%0d got %0d want %0d", k, d0[19:4], k - 1);
            else passed++;
            total++;
            if (d0[3:0] !== uni(l, 0) || d0[3:0] == 4'd0)
                $display("FAIL b2b_dest k=%0d got %0d want %0d", k, d0[3:0], uni(l, 0));
            else passed++;
            l = step16(l);
        end
        total++; if (fc0 !== 20'd19) $display("FAIL b2b_flits got %0d want 19", fc0); else passed++;
    endtask

    task automatic test_long_run();
        do_reset();
        send = 1'b1;
        repeat (300) tick();
        total++; if (fc0 !== 20'd299) $display("FAIL long_flits got %0d want 299", fc0); else passed++;
        total++; if (d0[19:4] !== 16'd299) $display("FAIL long_payload got %0d want 299", d0[19:4]); else passed++;
        total++; if (sc0 !== 20'd0) $display("FAIL long_stall got %0d want 0", sc0); else passed++;
    endtask

    task automatic test_stall_hold();
        logic [19:0] held;
        do_reset();
        send = 1'b1;
        tick();
        held = d0;
        busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (d0 !== held || v0 !== 1'b1)
                $display("FAIL stall_hold k=%0d got %h/%b want %h/1", k, d0, v0, held); else passed++;
        end
        total++; if (sc0 !== 20'd5) $display("FAIL stall_count got %0d want 5", sc0); else passed++;
        total++; if (fc0 !== 20'd0) $display("FAIL stall_flits got %0d want 0", fc0); else passed++;
        busy = 1'b0;
        tick();
        total++; if (fc0 !== 20'd1) $display("FAIL stall_release got %0d want 1", fc0); else passed++;
        total++; if (d0[19:4] !== 16'd1) $display("FAIL stall_next_payload got %0d want 1", d0[19:4]); else passed++;
        busy = 1'b1; send = 1'b0;
        tick();
        total++; if (v0 !== 1'b1 || d0[19:4] !== 16'd1)
            $display("FAIL send_drop_hold got %b/%0d want 1/1", v0, d0[19:4]); else passed++;
        total++; if (sc0 !== 20'd6) $display("FAIL send_drop_stall got %0d want 6", sc0); else passed++;
        busy = 1'b0;
        tick();
        total++; if (fc0 !== 20'd2 || v0 !== 1'b0)
            $display("FAIL send_drop_xfer got %0d/%b want 2/0", fc0, v0); else passed++;
    endtask

    task automatic test_max_pkts();
        do_reset();
        send = 1'b1;
        tick(); tick(); tick();
        total++; if (dnmax !== 1'b0 || fcmax !== 20'd2 || vmax !== 1'b1)
            $display("FAIL max_pre got %b/%0d/%b want 0/2/1", dnmax, fcmax, vmax); else passed++;
        tick();
        total++; if (dnmax !== 1'b1 || fcmax !== 20'd3 || vmax !== 1'b0)
            $display("FAIL max_done got %b/%0d/%b want 1/3/0", dnmax, fcmax, vmax); else passed++;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++; if (dnmax !== 1'b1 || fcmax !== 20'd3 || vmax !== 1'b0)
                $display("FAIL max_after k=%0d got %b/%0d/%b want 1/3/0", k, dnmax, fcmax, vmax); else passed++;
        end
        total++; if (dn0 !== 1'b0) $display("FAIL unlimited_done got %b want 0", dn0); else passed++;
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        send = 1'b1;
        tick();
        busy = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        total++; if (v0 !== 1'b0 || fc0 !== 20'd0 || sc0 !== 20'd0 || d0 !== 20'd0)
            $display("FAIL hold_reset got %b/%0d/%0d/%h want 0/0/0/0", v0, fc0, sc0, d0); else passed++;
        reset = 1'b0; busy = 1'b0;
        tick();
        total++; if (v0 !== 1'b1 || d0[19:4] !== 16'd0)
            $display("FAIL hold_reset_first got %b/%0d want 1/0", v0, d0[19:4]); else passed++;
        tick();
        total++; if (fc0 !== 20'd1) $display("FAIL hold_reset_count got %0d want 1", fc0); else passed++;
    endtask

    task automatic test_transpose();
        do_reset();
        send = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++; if (vtr5 !== 1'b1 || dtr5[3:0] !== 4'd7)
                $display("FAIL tr5_dest k=%0d got %b/%0d want 1/7", k, vtr5, dtr5[3:0]); else passed++;
            total++; if (vtr4 !== 1'b0) $display("FAIL tr4_valid k=%0d got %b want 0", k, vtr4); else passed++;
        end
        total++; if (fctr4 !== 20'd0) $display("FAIL tr4_flits got %0d want 0", fctr4); else passed++;
    endtask

    task automatic test_hotspot();
        logic [15:0] l0, l4;
        logic [3:0]  e0;
        do_reset();
        l0 = 16'hACE1;
        l4 = 16'hACE5;
        send = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            e0 = (l0[15:8] < 8'd255) ? 4'd4 : uni(l0, 0);
            total++; if (vh0 !== 1'b1 || dh0[3:0] !== e0)
                $display("FAIL hot0_dest k=%0d got %b/%0d want 1/%0d", k, vh0, dh0[3:0], e0); else passed++;
            total++; if (vh4 !== 1'b1 || dh4[3:0] !== uni(l4, 4) || dh4[3:0] == 4'd4)
                $display("FAIL hot4_dest k=%0d got %b/%0d want 1/%0d", k, vh4, dh4[3:0], uni(l4, 4)); else passed++;
            l0 = step16(l0);
            l4 = step16(l4);
        end
    endtask

    task automatic test_pir_zero();
        logic seen;
        do_reset();
        send = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (vp0 !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0 || fcp0 !== 20'd0)
            $display("FAIL pir0_never got %b/%0d want 0/0", seen, fcp0); else passed++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_long_run();
        test_stall_hold();
        test_max_pkts();
        test_reset_in_hold();
        test_transpose();
        test_hotspot();
        test_pir_zero();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
